mini_fir_decim: RTL and testbench

Downstream stage of the mini FIR filter. Consumes the filter's 8-bit output stream (one sample per clock), block-averages 2^DEC_LOG2 consecutive samples and buffers the averaged results in a small first-word-fall-through FIFO. The FIFO is drained through a valid/ready handshake. Overflow is reported with a sticky flag.

---
 rtl/mini_fir_decim_if.sv | 23 ++
 rtl/mini_fir_decim.sv | 81 ++++++++
 tb/tb_mini_fir_decim.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/mini_fir_decim_if.sv
// mini_fir_decim_if: sample input, FIFO drain handshake and status of the decimator
interface mini_fir_decim_if #(
    parameter int FIFO_AW = 2
);
    logic               i_en;
    logic [7:0]         i_din;
    logic               i_ready;
    logic               i_clr_ovf;
    logic               o_valid;
    logic [7:0]         o_data;
    logic [FIFO_AW:0]   o_level;
    logic               o_overflow;

    modport master (
        output i_en, i_din, i_ready, i_clr_ovf,
        input  o_valid, o_data, o_level, o_overflow
    );

    modport slave (
        input  i_en, i_din, i_ready, i_clr_ovf,
        output o_valid, o_data, o_level, o_overflow
    );
endinterface

// File: rtl/mini_fir_decim.sv
// mini_fir_decim: block-average 2^DEC_LOG2 samples into a first-word-fall-through FIFO with sticky overflow
module mini_fir_decim #(
    parameter int DEC_LOG2 = 2,
    parameter int FIFO_AW  = 2
) (
    input logic             clk,
    input logic             rst,
    mini_fir_decim_if.slave bus
);
    localparam int AW = 8 + DEC_LOG2;
    localparam int D  = 1 << FIFO_AW;

    logic [AW-1:0]      r_acc;
    logic [7:0]         r_mem [D];
    logic [FIFO_AW-1:0] r_wp;
    logic [FIFO_AW-1:0] r_rp;
    logic [FIFO_AW:0]   r_level;
    logic               r_ovf;
    logic [AW-1:0]      w_sum;
    logic [7:0]         w_res;
    logic               w_last;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_wr;
    logic               w_drop;

    assign w_sum  = r_acc + AW'(bus.i_din);
    assign w_res  = w_sum[DEC_LOG2 +: 8];
    assign w_push = bus.i_en & w_last;
    assign w_pop  = (r_level != '0) & bus.i_ready;
    assign w_full = r_level == (FIFO_AW+1)'(D);
    // a full FIFO still accepts the new result when the head leaves in the same cycle
    assign w_wr   = w_push & (~w_full | w_pop);
    assign w_drop = w_push & w_full & ~w_pop;

    generate
        if (DEC_LOG2 == 0) begin : g_nocnt
            assign w_last = 1'b1;
        end else begin : g_cnt
            logic [DEC_LOG2-1:0] r_cnt;
            // sample position within the current block; any gap in i_en restarts the block
            always_ff @(posedge clk) begin
                if (rst || !bus.i_en || w_last) r_cnt <= '0;
                else                            r_cnt <= r_cnt + DEC_LOG2'(1);
            end
            assign w_last = &r_cnt;
        end
    endgenerate

    // running block sum, emptied on completion or when the sample stream stops
    always_ff @(posedge clk) begin
        if (rst || !bus.i_en || w_last) r_acc <= '0;
        else                            r_acc <= w_sum;
    end

    // FIFO storage; contents are only meaningful below r_level so no reset is needed
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wp] <= w_res;
    end

    // FIFO pointers, occupancy and sticky overflow (a drop beats a clear)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_wp    <= w_wr  ? r_wp + FIFO_AW'(1) : r_wp;
            r_rp    <= w_pop ? r_rp + FIFO_AW'(1) : r_rp;
            r_level <= r_level + (FIFO_AW+1)'(w_wr) - (FIFO_AW+1)'(w_pop);
            r_ovf   <= w_drop ? 1'b1 : (bus.i_clr_ovf ? 1'b0 : r_ovf);
        end
    end

    assign bus.o_valid    = r_level != '0;
    assign bus.o_data     = (r_level != '0) ? r_mem[r_rp] : 8'd0;
    assign bus.o_level    = r_level;
    assign bus.o_overflow = r_ovf;
endmodule

// File: tb/tb_mini_fir_decim.sv
// tb_mini_fir_decim: scoreboard bench for the 4:1 averaging decimator with a 4-deep FIFO
module tb_mini_fir_decim;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   q[$];
    int   m_acc = 0;
    int   m_cnt = 0;
    bit   m_ovf = 1'b0;
    bit   armed = 1'b0;

    always #5 clk = ~clk;

    mini_fir_decim_if #(.FIFO_AW(2)) bus ();

    mini_fir_decim #(.DEC_LOG2(2), .FIFO_AW(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send(input bit e, input int d);
        bus.i_en  = e;
        bus.i_din = 8'(d);
        @(posedge clk);
        #1;
    endtask

    task automatic block(input int v);
        repeat (4) send(1'b1, v);
    endtask

    task automatic drain();
        int n = 0;
        while (bus.o_level != 0 && n < 20) begin
            send(1'b0, 0);
            n++;
        end
        check("drain", bus.o_level, 0);
    endtask

    // reference model: checks current outputs, then predicts the effect of the coming edge
    always @(negedge clk) begin
        int  s;
        bit  drop;
        if (armed) begin
            check("valid", bus.o_valid, q.size() != 0);
            check("level", bus.o_level, q.size());
            check("ovf", bus.o_overflow, m_ovf);
            if (q.size() == 0) check("data_idle", bus.o_data, 0);
        end
        if (rst) begin
            q.delete();
            m_acc = 0;
            m_cnt = 0;
            m_ovf = 1'b0;
            armed = 1'b1;
        end else begin
            if (q.size() != 0 && bus.i_ready) check("data", bus.o_data, q.pop_front());
            drop = 1'b0;
            if (bus.i_en) begin
                s = m_acc + int'(bus.i_din);
                if (m_cnt == 3) begin
                    if (q.size() < D) q.push_back(s >> 2);
                    else drop = 1'b1;
                    m_acc = 0;
                    m_cnt = 0;
                end else begin
                    m_acc = s;
                    m_cnt++;
                end
            end else begin
                m_acc = 0;
                m_cnt = 0;
            end
            if (drop) m_ovf = 1'b1;
            else if (bus.i_clr_ovf) m_ovf = 1'b0;
        end
    end

    initial begin
        bus.i_en      = 1'b1;
        bus.i_din     = 8'($urandom_range(0, 255));
        bus.i_ready   = 1'b0;
        bus.i_clr_ovf = 1'b0;
        send(1'b1, $urandom_range(0, 255));
        send(1'b1, $urandom_range(0, 255));
        check("rst_valid", bus.o_valid, 0);
        check("rst_data", bus.o_data, 0);
        check("rst_level", bus.o_level, 0);
        check("rst_ovf", bus.o_overflow, 0);
        rst = 1'b0;

        bus.i_ready = 1'b1;
        send(1'b1, 10);
        send(1'b1, 20);
        send(1'b1, 30);
        check("avg_early", bus.o_valid, 0);
        send(1'b1, 41);
        check("avg_valid", bus.o_valid, 1);
        check("avg_data", bus.o_data, 25);
        send(1'b0, 0);
        check("avg_one_cycle", bus.o_valid, 0);

        block(255);
        check("max_data", bus.o_data, 255);
        send(1'b0, 0);
        send(1'b1, 0);
        send(1'b1, 0);
        send(1'b1, 0);
        send(1'b1, 3);
        check("trunc_valid", bus.o_valid, 1);
        check("trunc_data", bus.o_data, 0);
        send(1'b0, 0);

        send(1'b1, 100);
        send(1'b1, 100);
        send(1'b0, 0);
        block(8);
        check("en_drop_data", bus.o_data, 8);
        send(1'b0, 0);
        check("en_drop_level", bus.o_level, 0);

        bus.i_ready = 1'b0;
        for (int k = 1; k <= 5; k++) block(k);
        check("ovf_level", bus.o_level, 4);
        check("ovf_set", bus.o_overflow, 1);
        check("ovf_head", bus.o_data, 1);
        send(1'b0, 0);
        bus.i_ready = 1'b1;
        drain();
        check("ovf_sticky", bus.o_overflow, 1);
        bus.i_clr_ovf = 1'b1;
        send(1'b0, 0);
        bus.i_clr_ovf = 1'b0;
        check("ovf_clear", bus.o_overflow, 0);

        bus.i_ready = 1'b0;
        for (int k = 6; k <= 9; k++) block(k);
        check("full_level", bus.o_level, 4);
        send(1'b1, 10);
        send(1'b1, 10);
        send(1'b1, 10);
        bus.i_ready = 1'b1;
        send(1'b1, 10);
        check("pushpop_level", bus.o_level, 4);
        check("pushpop_ovf", bus.o_overflow, 0);
        check("pushpop_head", bus.o_data, 7);
        drain();
        check("sb_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
